hdmi_video_port: RTL and testbench

- Parametrised RGBI-to-HDMI-transmitter port; successor to the single-bit CGA port.
- Sits between the CGA/MDA video generators and the external HDMI transmitter.
- Expands 4-bit RGBI into COLOR_BITS per channel through a fixed palette (CGA colour or MDA monochrome) and delay-aligns sync and DE with a programmable DE skew.
- Mode changes take effect only at frame boundaries; optional blanking forces black outside DE.

---
 rtl/hdmi_port_pkg.sv | 25 ++
 rtl/hdmi_video_port_sync_delay_line.sv | 27 ++
 rtl/hdmi_video_port.sv | 124 ++++++++++++
 tb/tb_hdmi_video_port.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hdmi_port_pkg.sv
// hdmi_port_pkg: palette constants and mode encodings shared by the HDMI video port.
`default_nettype none

package hdmi_port_pkg;

  localparam logic MODE_CGA = 1'b0;
  localparam logic MODE_MDA = 1'b1;

  localparam logic [3:0] BROWN_INDEX = 4'd6;
  localparam logic [7:0] BROWN_GREEN = 8'h55;

  // Indexed by {I,R,G,B}; entries are {R,G,B} at 8 bits per channel.
  localparam logic [0:15][23:0] CGA_PALETTE = {
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAAAA00, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

  // Indexed by {video[3], video[0]}.
  localparam logic [0:3][7:0] MDA_GREY = {8'h00, 8'hAA, 8'h55, 8'hFF};

endpackage

`default_nettype wire

// File: rtl/hdmi_video_port_sync_delay_line.sv
// sync_delay_line: DEPTH-stage shift register with every tap exposed; taps[0] is the newest.
`default_nettype none

module sync_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            din,
  output logic [DEPTH-1:0][WIDTH-1:0] taps
);

  always_ff @(posedge clk) begin
    if (reset) begin
      taps <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hdmi_video_port.sv
// hdmi_video_port: RGBI to HDMI transmitter port with CGA/MDA palette expansion,
// sync/DE alignment, frame-boundary mode switching and optional blanking.
`default_nettype none

module hdmi_video_port #(
  parameter int unsigned COLOR_BITS = 8,
  parameter int unsigned DE_SKEW    = 1,
  parameter bit          HS_INVERT  = 1'b0,
  parameter bit          VS_INVERT  = 1'b0,
  parameter bit          BLANK_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            video,
  input  logic                  display_enable,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  mode_req,
  input  logic                  brown_fix,
  output logic [COLOR_BITS-1:0] hdmi_red,
  output logic [COLOR_BITS-1:0] hdmi_grn,
  output logic [COLOR_BITS-1:0] hdmi_blu,
  output logic                  hdmi_hs,
  output logic                  hdmi_vs,
  output logic                  hdmi_de,
  output logic                  hdmi_clk,
  output logic                  mode_active
);

  import hdmi_port_pkg::*;

  localparam int unsigned DE_DEPTH = 2 + DE_SKEW;

  logic [1:0][1:0]          sync_taps;
  logic [DE_DEPTH-1:0][0:0] de_taps;
  logic                     vs_d1;
  logic                     de_next;
  logic [3:0]               s1_video;
  logic                     s1_brown;
  logic                     s1_mode;
  logic [23:0]              lut_rgb;
  logic [7:0]               mda_grey;
  logic                     unused_taps;

  sync_delay_line #(
    .DEPTH (2),
    .WIDTH (2)
  ) u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .din   ({hsync, vsync}),
    .taps  (sync_taps)
  );

  sync_delay_line #(
    .DEPTH (DE_DEPTH),
    .WIDTH (1)
  ) u_de_delay (
    .clk   (clk),
    .reset (reset),
    .din   (display_enable),
    .taps  (de_taps)
  );

  assign vs_d1    = sync_taps[0][0];
  assign hdmi_hs  = sync_taps[1][1] ^ HS_INVERT;
  assign hdmi_vs  = sync_taps[1][0] ^ VS_INVERT;
  assign hdmi_de  = de_taps[DE_DEPTH-1][0];
  // Value hdmi_de takes at the coming edge, so blanking lines up with the delayed DE.
  assign de_next  = de_taps[DE_DEPTH-2][0];
  assign hdmi_clk = clk;

  assign unused_taps = ^{sync_taps[0][1], de_taps};

  // Mode is only allowed to change on the rising edge of vsync.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_active <= mode_req;
    end else if (vsync && !vs_d1) begin
      mode_active <= mode_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_video <= '0;
      s1_brown <= 1'b0;
      s1_mode  <= 1'b0;
    end else begin
      s1_video <= video;
      s1_brown <= brown_fix;
      s1_mode  <= mode_active;
    end
  end

  always_comb begin
    lut_rgb  = CGA_PALETTE[s1_video];
    mda_grey = MDA_GREY[{s1_video[3], s1_video[0]}];
    case (s1_mode)
      MODE_MDA: lut_rgb = {3{mda_grey}};
      MODE_CGA: begin
        if (s1_brown && (s1_video == BROWN_INDEX)) begin
          lut_rgb[15:8] = BROWN_GREEN;
        end
      end
      default: lut_rgb = CGA_PALETTE[s1_video];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || (BLANK_EN && !de_next)) begin
      hdmi_red <= '0;
      hdmi_grn <= '0;
      hdmi_blu <= '0;
    end else begin
      hdmi_red <= lut_rgb[23 -: COLOR_BITS];
      hdmi_grn <= lut_rgb[15 -: COLOR_BITS];
      hdmi_blu <= lut_rgb[7  -: COLOR_BITS];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hdmi_video_port.sv
// tb_hdmi_video_port: randomized stimulus on two port configurations, checked against a
// cycle-history reference model of the palette, latency, blanking and mode rules.
`default_nettype none
`timescale 1ns/1ps

module tb_hdmi_video_port;

  localparam int NCYC = 4000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] video = 4'h0;
  logic       display_enable = 1'b0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic       mode_req = 1'b0;
  logic       brown_fix = 1'b0;

  logic [7:0] a_red, a_grn, a_blu;
  logic       a_hs, a_vs, a_de, a_clk, a_mode;
  logic [1:0] b_red, b_grn, b_blu;
  logic       b_hs, b_vs, b_de, b_clk, b_mode;

  hdmi_video_port #(
    .COLOR_BITS(8), .DE_SKEW(1), .HS_INVERT(1'b0), .VS_INVERT(1'b0), .BLANK_EN(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .video(video), .display_enable(display_enable),
    .hsync(hsync), .vsync(vsync), .mode_req(mode_req), .brown_fix(brown_fix),
    .hdmi_red(a_red), .hdmi_grn(a_grn), .hdmi_blu(a_blu), .hdmi_hs(a_hs),
    .hdmi_vs(a_vs), .hdmi_de(a_de), .hdmi_clk(a_clk), .mode_active(a_mode)
  );

  hdmi_video_port #(
    .COLOR_BITS(2), .DE_SKEW(0), .HS_INVERT(1'b1), .VS_INVERT(1'b1), .BLANK_EN(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .video(video), .display_enable(display_enable),
    .hsync(hsync), .vsync(vsync), .mode_req(mode_req), .brown_fix(brown_fix),
    .hdmi_red(b_red), .hdmi_grn(b_grn), .hdmi_blu(b_blu), .hdmi_hs(b_hs),
    .hdmi_vs(b_vs), .hdmi_de(b_de), .hdmi_clk(b_clk), .mode_active(b_mode)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Histories indexed by cycle: inputs driven in cycle c are sampled at edge c+1.
  bit       rst_h  [NCYC];
  bit [3:0] vid_h  [NCYC];
  bit       de_h   [NCYC];
  bit       hs_h   [NCYC];
  bit       vs_h   [NCYC];
  bit       mreq_h [NCYC];
  bit       brown_h[NCYC];
  bit       mode_h [NCYC];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit clean(input int from, input int upto);
    for (int i = from; i <= upto; i++) begin
      if (i < 0 || rst_h[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [23:0] palette(input bit [3:0] v, input bit brown, input bit mda);
    logic [7:0] r, g, b, grey;
    if (mda) begin
      case ({v[3], v[0]})
        2'b00:   grey = 8'h00;
        2'b01:   grey = 8'hAA;
        2'b10:   grey = 8'h55;
        default: grey = 8'hFF;
      endcase
      return {grey, grey, grey};
    end
    r = (v[2] ? 8'hAA : 8'h00) + (v[3] ? 8'h55 : 8'h00);
    g = (v[1] ? 8'hAA : 8'h00) + (v[3] ? 8'h55 : 8'h00);
    b = (v[0] ? 8'hAA : 8'h00) + (v[3] ? 8'h55 : 8'h00);
    if (v == 4'd6 && brown) g = 8'h55;
    return {r, g, b};
  endfunction

  task automatic check_port(input string p, input int cb, input int skew, input bit hinv,
                            input bit vinv, input bit blank, input logic [7:0] r,
                            input logic [7:0] g, input logic [7:0] b, input logic hs,
                            input logic vs, input logic de, input logic md, input logic hc);
    int          k;
    bit          de_e;
    logic [23:0] px;
    bit          hs_e, vs_e;
    k    = cyc - 2;
    de_e = clean(cyc - 2 - skew, cyc - 1) ? de_h[cyc - 2 - skew] : 1'b0;
    px   = clean(k, cyc - 1) ? palette(vid_h[k], brown_h[k], mode_h[k]) : 24'h0;
    hs_e = clean(k, cyc - 1) ? hs_h[k] : 1'b0;
    vs_e = clean(k, cyc - 1) ? vs_h[k] : 1'b0;
    if (blank && !de_e) px = 24'h0;
    check_eq({p, ".red"}, {24'h0, r}, 32'(px[23:16] >> (8 - cb)));
    check_eq({p, ".grn"}, {24'h0, g}, 32'(px[15:8]  >> (8 - cb)));
    check_eq({p, ".blu"}, {24'h0, b}, 32'(px[7:0]   >> (8 - cb)));
    check_eq({p, ".de"},   32'(de), 32'(de_e));
    check_eq({p, ".hs"},   32'(hs), 32'(hs_e ^ hinv));
    check_eq({p, ".vs"},   32'(vs), 32'(vs_e ^ vinv));
    check_eq({p, ".mode"}, 32'(md), 32'(mode_h[cyc]));
    check_eq({p, ".hclk"}, 32'(hc), 32'(clk));
  endtask

  initial begin
    int h = 0;
    int ln = 0;
    int rst_left = 0;
    mode_h[0] = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      cyc = c;
      #1;
      if (c >= 1) begin
        if (rst_h[c-1])
          mode_h[c] = mreq_h[c-1];
        else if (vs_h[c-1] && !(c >= 2 && vs_h[c-2] && !rst_h[c-2]))
          mode_h[c] = mreq_h[c-1];
        else
          mode_h[c] = mode_h[c-1];
      end
      if (c >= 6) begin
        check_port("A", 8, 1, 1'b0, 1'b0, 1'b1, a_red, a_grn, a_blu, a_hs, a_vs, a_de, a_mode, a_clk);
        check_port("B", 2, 0, 1'b1, 1'b1, 1'b0, {6'h0, b_red}, {6'h0, b_grn}, {6'h0, b_blu},
                   b_hs, b_vs, b_de, b_mode, b_clk);
      end

      if (c < 5) begin
        reset = 1'b1;
        video = 4'h0;
        display_enable = 1'b0;
        hsync = 1'b0;
        vsync = 1'b0;
        mode_req = 1'($urandom_range(1));
      end else if (c < 3000) begin
        if (rst_left > 0) begin
          reset = 1'b1;
          rst_left--;
        end else if ($urandom_range(399) == 0) begin
          reset = 1'b1;
          rst_left = $urandom_range(2);
        end else begin
          reset = 1'b0;
        end
        display_enable = (h < 30) && (ln < 6);
        hsync = (h >= 32) && (h < 37);
        vsync = (ln >= 6);
        video = ($urandom_range(3) == 0) ? 4'h6 : 4'($urandom);
        if ($urandom_range(59) == 0) mode_req = ~mode_req;
        if ($urandom_range(7) == 0) brown_fix = ~brown_fix;
        h++;
        if (h == 40) begin
          h = 0;
          ln = (ln + 1) % 8;
        end
      end else begin
        reset = ($urandom_range(99) == 0);
        video = 4'($urandom);
        display_enable = 1'($urandom);
        hsync = 1'($urandom);
        vsync = ($urandom_range(5) == 0) ? ~vsync : vsync;
        mode_req = 1'($urandom);
        brown_fix = 1'($urandom);
      end

      rst_h[c]   = reset;
      vid_h[c]   = video;
      de_h[c]    = display_enable;
      hs_h[c]    = hsync;
      vs_h[c]    = vsync;
      mreq_h[c]  = mode_req;
      brown_h[c] = brown_fix;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
